// File: rtl/sent_rx_pkg.sv
// Shared types and constants for the SENT receive path: FSM states, pulse
// class limits and the CRC-checker enable codes.
package sent_rx_pkg;

  typedef enum logic [2:0] {
    HUNT,
    STATUS,
    DATA,
    CRC_NIB,
    POST
  } rx_state_t;

  localparam int SYNC_TICKS = 56;
  localparam int NIB_MIN    = 12;
  localparam int NIB_MAX    = 27;
  localparam int PAUSE_MAX  = 768;

  localparam logic [2:0] FAST6 = 3'b001;
  localparam logic [2:0] FAST4 = 3'b010;
  localparam logic [2:0] FAST3 = 3'b011;

  // 2'b11 falls back to the 6-nibble format.
  function automatic logic [2:0] nib_count(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return 3'd4;
      2'b10:   return 3'd3;
      default: return 3'd6;
    endcase
  endfunction

  function automatic logic [2:0] enable_code(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return FAST4;
      2'b10:   return FAST3;
      default: return FAST6;
    endcase
  endfunction

endpackage

// File: rtl/sent_rx_pulse_timer.sv
// Falling-edge detector and rounded tick counter for the synchronised SENT line.
// period_ticks is the length of the period that ends on the current edge.
module sent_rx_pulse_timer #(
  parameter int CLKS_PER_TICK = 4,
  parameter int MAX_TICKS     = 1023
) (
  input  logic       clk_rx,
  input  logic       reset_rx,
  input  logic       sent_rx_in,
  output logic       edge_evt,
  output logic [9:0] period_ticks,
  output logic       timeout
);

  localparam int PW = $clog2(CLKS_PER_TICK);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLKS_PER_TICK / 2);
  localparam logic [9:0]    TICK_SAT   = 10'(MAX_TICKS);

  logic          sent_q;
  logic          armed;
  logic          fall;
  logic [PW-1:0] presc;
  logic [9:0]    ticks;

  assign fall = sent_q & ~sent_rx_in;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_rx) begin
    if (!reset_rx) begin
      sent_q <= 1'b0;
      armed  <= 1'b0;
      presc  <= '0;
      ticks  <= '0;
    end else begin
      sent_q <= sent_rx_in;
      if (fall) begin
        // Starting half-way through a tick makes the count round to nearest.
        presc <= PRESC_HALF;
        ticks <= '0;
        armed <= 1'b1;
      end else if (presc == PRESC_LAST) begin
        presc <= '0;
        if (ticks != TICK_SAT) ticks <= ticks + 10'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // The first edge after reset only opens a measurement window.
  assign edge_evt     = fall & armed;
  assign period_ticks = ticks;
  assign timeout      = (ticks == TICK_SAT);

endmodule

// File: rtl/sent_rx_frame_decode.sv
// SENT fast-channel frame decoder: classifies pulse periods, assembles the
// frame and runs the one-frame-at-a-time handshake with the CRC checker.
module sent_rx_frame_decode
  import sent_rx_pkg::*;
#(
  parameter int CLKS_PER_TICK = 4,
  parameter int SYNC_TOL      = 1,
  parameter int MAX_TICKS     = 1023
) (
  input  logic        clk_rx,
  input  logic        reset_rx,
  input  logic        sent_rx_in,
  input  logic [1:0]  cfg_data_nibbles,
  input  logic [1:0]  crc_check_done,
  input  logic        valid_data_fast,
  output logic [2:0]  enable_crc_check,
  output logic [27:0] data_fast_check_crc,
  output logic [3:0]  status_nibble,
  output logic        rx_frame_done,
  output logic        rx_frame_ok,
  output logic        frame_error,
  output logic        overrun
);

  logic       edge_evt;
  logic       timeout;
  logic [9:0] period_ticks;

  sent_rx_pulse_timer #(
    .CLKS_PER_TICK(CLKS_PER_TICK),
    .MAX_TICKS    (MAX_TICKS)
  ) u_timer (
    .clk_rx      (clk_rx),
    .reset_rx    (reset_rx),
    .sent_rx_in  (sent_rx_in),
    .edge_evt    (edge_evt),
    .period_ticks(period_ticks),
    .timeout     (timeout)
  );

  logic is_sync, is_nib, is_pause;
  logic [3:0] nib_val;

  assign is_sync  = (period_ticks >= 10'(SYNC_TICKS - SYNC_TOL)) &&
                    (period_ticks <= 10'(SYNC_TICKS + SYNC_TOL));
  assign is_nib   = (period_ticks >= 10'(NIB_MIN)) && (period_ticks <= 10'(NIB_MAX));
  assign is_pause = (period_ticks >= 10'(NIB_MIN)) && (period_ticks <= 10'(PAUSE_MAX)) && !is_sync;
  assign nib_val  = 4'(period_ticks - 10'(NIB_MIN));

  rx_state_t   state, state_nxt;
  logic [3:0]  status_q;
  logic [1:0]  cfg_q;
  logic [2:0]  nib_cnt;
  logic [23:0] shift_q;
  logic        pause_seen;
  logic        busy;
  logic [2:0]  launch_code;

  logic err, latch_status, shift_en, submit, pause_set, pause_clr;
  logic done_now;

  assign done_now = busy && (crc_check_done == 2'b01);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    err          = 1'b0;
    latch_status = 1'b0;
    shift_en     = 1'b0;
    submit       = 1'b0;
    pause_set    = 1'b0;
    pause_clr    = 1'b0;
    if (timeout && state != HUNT) begin
      err       = 1'b1;
      state_nxt = HUNT;
    end else if (edge_evt) begin
      case (state)
        HUNT: if (is_sync) state_nxt = STATUS;
        STATUS: begin
          if (is_nib) begin
            latch_status = 1'b1;
            state_nxt    = DATA;
          end else if (is_sync) begin
            err = 1'b1;
          end else begin
            err       = 1'b1;
            state_nxt = HUNT;
          end
        end
        DATA, CRC_NIB: begin
          if (is_nib) begin
            if (state == CRC_NIB) begin
              submit    = 1'b1;
              pause_clr = 1'b1;
              state_nxt = POST;
            end else begin
              shift_en = 1'b1;
              if (nib_cnt + 3'd1 == nib_count(cfg_q)) state_nxt = CRC_NIB;
            end
          end else begin
            err       = 1'b1;
            state_nxt = is_sync ? STATUS : HUNT;
          end
        end
        POST: begin
          if (is_sync) begin
            pause_clr = 1'b1;
            state_nxt = STATUS;
          end else if (is_pause && !pause_seen) begin
            pause_set = 1'b1;
          end else begin
            err       = 1'b1;
            state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_rx) begin
    if (!reset_rx) begin
      state               <= HUNT;
      status_q            <= '0;
      cfg_q               <= '0;
      nib_cnt             <= '0;
      shift_q             <= '0;
      pause_seen          <= 1'b0;
      busy                <= 1'b0;
      launch_code         <= '0;
      enable_crc_check    <= '0;
      data_fast_check_crc <= '0;
      status_nibble       <= '0;
      rx_frame_done       <= 1'b0;
      rx_frame_ok         <= 1'b0;
      frame_error         <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_error   <= err;
      rx_frame_done <= 1'b0;
      overrun       <= 1'b0;

      if (latch_status) begin
        status_q <= nib_val;
        cfg_q    <= cfg_data_nibbles;
        nib_cnt  <= '0;
        shift_q  <= '0;
      end
      if (shift_en) begin
        shift_q <= {shift_q[19:0], nib_val};
        nib_cnt <= nib_cnt + 3'd1;
      end
      if (pause_clr)      pause_seen <= 1'b0;
      else if (pause_set) pause_seen <= 1'b1;

      // A frame that met a same-cycle done launches one cycle later, so the
      // checker always observes enable at zero between frames.
      if (launch_code != 3'b000) begin
        enable_crc_check <= launch_code;
        busy             <= 1'b1;
        launch_code      <= '0;
      end
      if (done_now) begin
        enable_crc_check <= '0;
        busy             <= 1'b0;
        rx_frame_done    <= 1'b1;
        rx_frame_ok      <= valid_data_fast;
      end
      if (submit) begin
        if (busy && !done_now) begin
          overrun <= 1'b1;
        end else begin
          data_fast_check_crc <= {shift_q, nib_val};
          status_nibble       <= status_q;
          if (done_now) begin
            launch_code <= enable_code(cfg_q);
          end else begin
            enable_crc_check <= enable_code(cfg_q);
            busy             <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sent_rx_frame_decode.sv
// Directed bench for sent_rx_frame_decode: a frame-level model predicts the
// handshake outputs and pulses, compared every cycle, plus literal pins.
module tb_sent_rx_frame_decode;

  localparam int CPT        = 4;
  localparam int TOL        = 1;
  localparam int MAXT       = 1023;
  localparam int LOW_CLKS   = 4 * CPT;
  localparam int RESP_DELAY = 6;

  logic        clk_rx, reset_rx, sent_rx_in;
  logic [1:0]  cfg_data_nibbles, crc_check_done;
  logic        valid_data_fast;
  logic [2:0]  enable_crc_check;
  logic [27:0] data_fast_check_crc;
  logic [3:0]  status_nibble;
  logic        rx_frame_done, rx_frame_ok, frame_error, overrun;

  sent_rx_frame_decode #(
    .CLKS_PER_TICK(CPT),
    .SYNC_TOL     (TOL),
    .MAX_TICKS    (MAXT)
  ) dut (
    .clk_rx             (clk_rx),
    .reset_rx           (reset_rx),
    .sent_rx_in         (sent_rx_in),
    .cfg_data_nibbles   (cfg_data_nibbles),
    .crc_check_done     (crc_check_done),
    .valid_data_fast    (valid_data_fast),
    .enable_crc_check   (enable_crc_check),
    .data_fast_check_crc(data_fast_check_crc),
    .status_nibble      (status_nibble),
    .rx_frame_done      (rx_frame_done),
    .rx_frame_ok        (rx_frame_ok),
    .frame_error        (frame_error),
    .overrun            (overrun)
  );

  initial clk_rx = 1'b0;
  always #5 clk_rx = ~clk_rx;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model state
  typedef enum {M_HUNT, M_STATUS, M_DATA, M_CRC, M_POST} m_state_t;
  m_state_t   m_state;
  bit         have_pending;
  int         pending;
  int         m_n;
  logic [3:0] m_status;
  logic [3:0] m_nibs[$];
  bit         m_pause_seen;
  bit         m_busy;

  logic [2:0]  exp_enable;
  logic [27:0] exp_data;
  logic [3:0]  exp_status;
  bit exp_done, exp_ok, exp_ferr, exp_ovr;
  bit cmp_en = 1'b0;

  bit auto_resp, resp_valid, done_driven;
  int wait_cnt;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  function automatic int n_of(input logic [1:0] c);
    return (c == 2'b01) ? 4 : (c == 2'b10) ? 3 : 6;
  endfunction

  function automatic logic [2:0] code_of(input int n);
    return (n == 6) ? 3'd1 : (n == 4) ? 3'd2 : 3'd3;
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; have_pending = 0; pending = 0; m_n = 6;
    m_status = '0; m_nibs.delete(); m_pause_seen = 0; m_busy = 0;
    exp_enable = '0; exp_data = '0; exp_status = '0;
    exp_done = 0; exp_ok = 0; exp_ferr = 0; exp_ovr = 0;
    done_driven = 0; wait_cnt = 0; auto_resp = 0;
    crc_check_done = 2'b00;
  endtask

  // Applies the protocol rules to one measured period of p ticks.
  task automatic model_eval(input int p);
    bit s, nb, ps;
    logic [3:0]  v;
    logic [27:0] w;
    s  = (p >= 56 - TOL) && (p <= 56 + TOL);
    nb = (p >= 12) && (p <= 27);
    ps = (p >= 12) && (p <= 768) && !s;
    v  = 4'(p - 12);
    case (m_state)
      M_HUNT: if (s) m_state = M_STATUS;
      M_STATUS: begin
        if (nb) begin
          m_status = v; m_n = n_of(cfg_data_nibbles); m_nibs.delete(); m_state = M_DATA;
        end else if (s) exp_ferr = 1;
        else begin exp_ferr = 1; m_state = M_HUNT; end
      end
      M_DATA: begin
        if (nb) begin
          m_nibs.push_back(v);
          if (m_nibs.size() == m_n) m_state = M_CRC;
        end else begin
          exp_ferr = 1; m_state = s ? M_STATUS : M_HUNT;
        end
      end
      M_CRC: begin
        if (nb) begin
          w = '0;
          foreach (m_nibs[k]) w = (w << 4) | 28'(m_nibs[k]);
          w = (w << 4) | 28'(v);
          if (m_busy) exp_ovr = 1;
          else begin
            exp_data = w; exp_status = m_status; exp_enable = code_of(m_n); m_busy = 1;
          end
          m_pause_seen = 0; m_state = M_POST;
        end else begin
          exp_ferr = 1; m_state = s ? M_STATUS : M_HUNT;
        end
      end
      M_POST: begin
        if (s) begin m_pause_seen = 0; m_state = M_STATUS; end
        else if (ps && !m_pause_seen) m_pause_seen = 1;
        else begin exp_ferr = 1; m_state = M_HUNT; end
      end
      default: m_state = M_HUNT;
    endcase
  endtask

  // One SENT period of L ticks starting with a falling edge; that edge ends
  // the previous period, which the model evaluates when the DUT reacts.
  task automatic send_period(input int L);
    sent_rx_in = 1'b0;
    @(posedge clk_rx); #1;
    exp_ferr = 0; exp_ovr = 0;
    if (have_pending) model_eval(pending);
    pending = (L > MAXT) ? MAXT : L;
    have_pending = 1;
    for (int i = 1; i < L * CPT; i++) begin
      sent_rx_in = (i < LOW_CLKS) ? 1'b0 : 1'b1;
      @(posedge clk_rx); #1;
      exp_ferr = 0; exp_ovr = 0;
      // Ticks elapsed are rounded clock counts; the error appears one cycle after saturation.
      if (m_state != M_HUNT && ((i - 1) + CPT / 2) / CPT >= MAXT) begin
        exp_ferr = 1; m_state = M_HUNT;
      end
    end
  endtask

  task automatic send_frame(input logic [3:0] st, input int n, input logic [23:0] d,
                            input logic [3:0] crc);
    send_period(12 + int'(st));
    for (int k = n - 1; k >= 0; k--) send_period(12 + int'(d[4*k +: 4]));
    send_period(12 + int'(crc));
  endtask

  task automatic release_done(input bit v);
    resp_valid = v; auto_resp = 1;
    repeat (30) @(posedge clk_rx);
    #1 auto_resp = 0;
  endtask

  task automatic frame_end_check(input int L, input logic [2:0] en_lit,
                                 input logic [27:0] data_lit, input logic [3:0] st_lit,
                                 input bit v);
    fork
      send_period(L);
      begin
        repeat (3) @(posedge clk_rx);
        #1;
        check("lit_enable", enable_crc_check, en_lit);
        check("lit_data", data_fast_check_crc, data_lit);
        check("lit_status", status_nibble, st_lit);
        release_done(v);
      end
    join
  endtask

  task automatic do_reset();
    cmp_en = 0;
    model_reset();
    reset_rx = 1'b0; sent_rx_in = 1'b1;
    @(posedge clk_rx); #1;
    check("rst_enable", enable_crc_check, 0);
    check("rst_data", data_fast_check_crc, 0);
    check("rst_status", status_nibble, 0);
    check("rst_done", rx_frame_done, 0);
    check("rst_ok", rx_frame_ok, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovr", overrun, 0);
    repeat (2) @(posedge clk_rx);
    #1 reset_rx = 1'b1;
    repeat (4) @(posedge clk_rx);
    #1 cmp_en = 1;
  endtask

  // Checker stand-in: answers a busy frame after a delay, with junk codes first.
  initial begin
    forever begin
      @(posedge clk_rx); #2;
      exp_done = 0;
      if (done_driven) begin
        done_driven = 0; crc_check_done = 2'b00;
        if (m_busy) begin
          exp_enable = '0; exp_done = 1; exp_ok = resp_valid; m_busy = 0;
        end
      end else if (m_busy && auto_resp) begin
        wait_cnt++;
        if (wait_cnt == 2)      crc_check_done = 2'b11;
        else if (wait_cnt == 3) crc_check_done = 2'b10;
        else if (wait_cnt >= RESP_DELAY) begin
          crc_check_done = 2'b01; valid_data_fast = resp_valid;
          done_driven = 1; wait_cnt = 0;
        end else crc_check_done = 2'b00;
      end else begin
        crc_check_done = 2'b00;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_rx);
      if (frame_error) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (cmp_en) begin
        check("cyc_enable", enable_crc_check, exp_enable);
        check("cyc_data", data_fast_check_crc, exp_data);
        check("cyc_status", status_nibble, exp_status);
        check("cyc_done", rx_frame_done, exp_done);
        if (exp_done) check("cyc_ok", rx_frame_ok, exp_ok);
        check("cyc_ferr", frame_error, exp_ferr);
        check("cyc_ovr", overrun, exp_ovr);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    reset_rx = 1'b0; sent_rx_in = 1'b1; cfg_data_nibbles = 2'b00;
    crc_check_done = 2'b00; valid_data_fast = 1'b0;
    do_reset();

    // 6-nibble frame, CRC passes
    cfg_data_nibbles = 2'b00;
    send_period(56);
    send_frame(4'h3, 6, 24'h123456, 4'hA);
    frame_end_check(56, 3'b001, 28'h123456A, 4'h3, 1'b1);

    // 3-nibble frame, CRC fails; 57-tick sync accepted afterwards
    cfg_data_nibbles = 2'b10;
    send_frame(4'h5, 3, 24'h000789, 4'h0);
    frame_end_check(57, 3'b011, 28'h0007890, 4'h5, 1'b0);

    // 30-tick nibble in DATA, then 58-tick "sync" ignored in HUNT, then recovery
    f0 = ferr_cnt;
    cfg_data_nibbles = 2'b01;
    send_period(12 + 4'hC);
    send_period(16);
    send_period(30);
    send_period(58);
    send_period(56);
    send_frame(4'h1, 4, 24'h00FEDC, 4'h5);
    frame_end_check(56, 3'b010, 28'h00FEDC5, 4'h1, 1'b1);
    check("bad_nib_err_count", 32'(ferr_cnt - f0), 1);

    // One pause is fine, a second pause is an error
    f0 = ferr_cnt;
    cfg_data_nibbles = 2'b00;
    send_frame(4'h0, 6, 24'h987654, 4'h3);
    frame_end_check(300, 3'b001, 28'h9876543, 4'h0, 1'b1);
    send_period(56);
    send_frame(4'h7, 6, 24'hABCDEF, 4'h1);
    frame_end_check(300, 3'b001, 28'hABCDEF1, 4'h7, 1'b1);
    send_period(300);
    send_period(56);
    check("pause_err_count", 32'(ferr_cnt - f0), 1);

    // Line held high in DATA: one timeout error, saturated period ignored in HUNT
    f0 = ferr_cnt;
    send_period(12 + 2);
    send_period(13);
    send_period(14);
    send_period(1100);
    send_period(56);
    check("timeout_err_count", 32'(ferr_cnt - f0), 1);

    // Done withheld: second frame overruns and is dropped
    send_frame(4'h2, 6, 24'h111111, 4'h2);
    send_period(56);
    send_frame(4'h3, 6, 24'h222222, 4'h3);
    fork
      send_period(56);
      begin
        @(posedge clk_rx); #1;
        check("lit_overrun", overrun, 1);
        check("lit_ovr_data", data_fast_check_crc, 28'h1111112);
        check("lit_ovr_enable", enable_crc_check, 3'b001);
      end
    join
    check("overrun_count", ovr_cnt, 1);

    // Reset while busy drops enable at once
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
